// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   state_e : controller FSM states
//   err_e   : response error codes carried on resp_err
//   F3_*    : RV32I funct3 encodings for access size and sign
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ILLEGAL  = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for one load/store access.
//   store_i   : 1 = store, 0 = load
//   funct3_i  : access size/sign
//   ea_lo_i   : effective address bits [1:0]
//   wdata_i   : raw store data (rs2)
//   rdata_i   : raw bus read word
//   illegal_o : funct3 not legal for this access kind
//   misalign_o: half/word access not naturally aligned
//   wstrb_o   : byte enables for the bus
//   wdata_o   : store data replicated onto the byte lanes
//   ldata_o   : selected and extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  ea_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic        illegal_o,
    output logic        misalign_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic        is_b, is_h, is_w;
    logic [31:0] rshift;

    // funct3[1:0] encodes the size; funct3[2] only selects zero-extension.
    assign is_b = (funct3_i[1:0] == 2'b00);
    assign is_h = (funct3_i[1:0] == 2'b01);
    assign is_w = (funct3_i[1:0] == 2'b10);

    always_comb begin
        if (store_i) begin
            illegal_o = !(funct3_i == F3_B || funct3_i == F3_H || funct3_i == F3_W);
        end else begin
            illegal_o = !(funct3_i == F3_B || funct3_i == F3_H || funct3_i == F3_W ||
                          funct3_i == F3_BU || funct3_i == F3_HU);
        end
    end

    assign misalign_o = (is_h && ea_lo_i[0]) || (is_w && (ea_lo_i != 2'b00));

    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = wdata_i;
        if (is_b) begin
            wstrb_o = 4'b0001 << ea_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
        end else if (is_h) begin
            wstrb_o = 4'b0011 << ea_lo_i;
            wdata_o = {2{wdata_i[15:0]}};
        end else if (is_w) begin
            wstrb_o = 4'b1111;
        end
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign rshift = rdata_i >> {ea_lo_i, 3'b000};

    always_comb begin
        ldata_o = 32'h0;
        case (funct3_i)
            F3_B:    ldata_o = {{24{rshift[7]}}, rshift[7:0]};
            F3_BU:   ldata_o = {24'h0, rshift[7:0]};
            F3_H:    ldata_o = {{16{rshift[15]}}, rshift[15:0]};
            F3_HU:   ldata_o = {16'h0, rshift[15:0]};
            F3_W:    ldata_o = rdata_i;
            default: ldata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller between execute and the data-memory bus.
// Accepts one request per handshake, checks legality/alignment, runs one
// bus transaction under a timeout and returns a one-cycle response.
//   req_*  : request from execute (valid/ready handshake)
//   mem_*  : word-aligned data-memory bus request, held until mem_ack
//   resp_* : one-cycle completion pulse with load data or error code
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [11:0] req_imm,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e         state_q, state_d;
    err_e           err_q, err_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [31:0]    ea_q, ea_d;
    logic           we_q, we_d;
    logic [2:0]     f3_q, f3_d;
    logic [3:0]     wstrb_q, wstrb_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;

    logic [31:0]    ea;
    logic           idle;
    logic           al_illegal, al_misalign;
    logic [3:0]     al_wstrb;
    logic [31:0]    al_wdata, al_ldata;

    assign ea   = req_base + {{20{req_imm[11]}}, req_imm};
    assign idle = (state_q == IDLE);

    // The single aligner sees the live request while idle (for checks and
    // capture) and the captured access afterwards (for load extension).
    lsu_align u_align (
        .store_i   (idle ? req_store  : we_q),
        .funct3_i  (idle ? req_funct3 : f3_q),
        .ea_lo_i   (idle ? ea[1:0]    : ea_q[1:0]),
        .wdata_i   (req_wdata),
        .rdata_i   (mem_rdata),
        .illegal_o (al_illegal),
        .misalign_o(al_misalign),
        .wstrb_o   (al_wstrb),
        .wdata_o   (al_wdata),
        .ldata_o   (al_ldata)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        timer_d = timer_q;
        ea_d    = ea_q;
        we_d    = we_q;
        f3_d    = f3_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ea_d    = ea;
                    we_d    = req_store;
                    f3_d    = req_funct3;
                    wstrb_d = al_wstrb;
                    wdata_d = al_wdata;
                    rdata_d = 32'h0;
                    timer_d = '0;
                    if (al_illegal) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = DONE;
                    end else if (al_misalign) begin
                        err_d   = ERR_MISALIGN;
                        state_d = DONE;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                timer_d = timer_q + TW'(1);
                // Ack beats an expiring timer in the same cycle.
                if (mem_ack) begin
                    rdata_d = we_q ? 32'h0 : al_ldata;
                    err_d   = ERR_OK;
                    state_d = DONE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    rdata_d = 32'h0;
                    err_d   = ERR_TIMEOUT;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= ERR_OK;
            timer_q <= '0;
            ea_q    <= 32'h0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            wstrb_q <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            ea_q    <= ea_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus and response outputs are gated by state so they read 0 elsewhere
    // and fall immediately when reset forces the state back to IDLE.
    assign req_ready  = idle;
    assign mem_req    = (state_q == BUS);
    assign mem_we     = mem_req & we_q;
    assign mem_addr   = mem_req ? {ea_q[31:2], 2'b00} : 32'h0;
    assign mem_wstrb  = mem_req ? wstrb_q : 4'h0;
    assign mem_wdata  = mem_req ? wdata_q : 32'h0;
    assign resp_valid = (state_q == DONE);
    assign resp_data  = resp_valid ? rdata_q : 32'h0;
    assign resp_err   = resp_valid ? err_q : ERR_OK;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [11:0] req_imm;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;

    int errors = 0;
    int checks = 0;

    lsu_ctrl #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_store (req_store),
        .req_funct3(req_funct3),
        .req_base  (req_base),
        .req_imm   (req_imm),
        .req_wdata (req_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request from a negedge and follow it to its response.
    // ack_at: BUS cycle index (0-based) in which mem_ack is raised; -1 = never.
    task automatic run(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] base, input logic [11:0] imm,
                       input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                       input logic [31:0] e_addr, input logic [3:0] e_strb,
                       input logic [31:0] e_wdata, input int e_cycles,
                       input logic [31:0] e_data, input logic [1:0] e_err);
        int n;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_base   = base;
        req_imm    = imm;
        req_wdata  = wd;
        mem_rdata  = rd;
        mem_ack    = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".ready_busy"}, 32'(req_ready), 32'h0);
        if (e_cycles > 0) begin
            chk({tag, ".addr"},  mem_addr, e_addr);
            chk({tag, ".strb"},  32'(mem_wstrb), 32'(e_strb));
            chk({tag, ".we"},    32'(mem_we), 32'(st));
            if (st) chk({tag, ".wdata"}, mem_wdata, e_wdata);
        end
        n = 0;
        while (mem_req && n < 100) begin
            mem_ack = (n == ack_at);
            @(negedge clk);
            n++;
        end
        mem_ack = 1'b0;
        chk({tag, ".bus_cycles"}, 32'(n), 32'(e_cycles));
        chk({tag, ".resp_valid"}, 32'(resp_valid), 32'h1);
        chk({tag, ".resp_data"},  resp_data, e_data);
        chk({tag, ".resp_err"},   32'(resp_err), 32'(e_err));
        @(negedge clk);
        chk({tag, ".resp_pulse"}, 32'(resp_valid), 32'h0);
        chk({tag, ".ready_back"}, 32'(req_ready), 32'h1);
    endtask

    initial begin
        int seen;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_base   = 32'h0;
        req_imm    = 12'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst.ready",      32'(req_ready), 32'h1);
        chk("rst.mem_req",    32'(mem_req), 32'h0);
        chk("rst.resp_valid", 32'(resp_valid), 32'h0);
        chk("rst.mem_addr",   mem_addr, 32'h0);
        chk("rst.resp_data",  resp_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        //   tag      st  f3      base          imm     wdata         rdata        ack  addr          strb  wdata         cyc data          err
        run("lb",    0, 3'b000, 32'h0000_1000, 12'h003, 32'h0,        32'h80FF_0000, 0, 32'h0000_1000, 4'h8, 32'h0,        1, 32'hFFFF_FF80, 2'b00);
        run("sh",    1, 3'b001, 32'h0000_2000, 12'hFFE, 32'h1234_ABCD, 32'h0,       0, 32'h0000_1FFC, 4'hC, 32'hABCD_ABCD, 1, 32'h0,        2'b00);
        run("sb",    1, 3'b000, 32'h0000_2000, 12'h001, 32'h0000_005A, 32'h0,       2, 32'h0000_2000, 4'h2, 32'h5A5A_5A5A, 3, 32'h0,        2'b00);
        run("lw_mis",0, 3'b010, 32'h0000_0001, 12'h000, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        0, 32'h0,        2'b01);
        run("lh_mis",0, 3'b001, 32'h0000_0003, 12'h000, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        0, 32'h0,        2'b01);
        run("ld_011",0, 3'b011, 32'h0000_0001, 12'h000, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        0, 32'h0,        2'b10);
        run("st_100",1, 3'b100, 32'h0000_0000, 12'h000, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        0, 32'h0,        2'b10);
        run("lhu_to",0, 3'b101, 32'h0000_3002, 12'h000, 32'h0,        32'hFFFF_0000, -1, 32'h0000_3000, 4'hC, 32'h0,      16, 32'h0,        2'b11);
        run("ack_edge",0,3'b010, 32'h0000_3000, 12'h000, 32'h0,        32'h1357_9BDF, 15, 32'h0000_3000, 4'hF, 32'h0,      16, 32'h1357_9BDF, 2'b00);
        run("lw_wrap",0, 3'b010, 32'hFFFF_FFFF, 12'h001, 32'h0,        32'hDEAD_BEEF, 0, 32'h0000_0000, 4'hF, 32'h0,        1, 32'hDEAD_BEEF, 2'b00);
        run("lh_sx", 0, 3'b001, 32'h0000_0102, 12'h000, 32'h0,        32'h8001_0000, 1, 32'h0000_0100, 4'hC, 32'h0,        2, 32'hFFFF_8001, 2'b00);

        // Reset in the middle of a bus access, then a late ack.
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_base   = 32'h0000_4000;
        req_imm    = 12'h000;
        mem_ack    = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort.in_bus", 32'(mem_req), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("abort.req_drop", 32'(mem_req), 32'h0);
        @(negedge clk);
        rst     = 1'b0;
        mem_ack = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        mem_ack = 1'b0;
        chk("abort.no_resp", 32'(seen), 32'h0);
        chk("abort.ready",   32'(req_ready), 32'h1);
        run("after", 0, 3'b100, 32'h0000_5001, 12'h000, 32'h0, 32'h0000_AB00, 0, 32'h0000_5000, 4'h2, 32'h0, 1, 32'h0000_00AB, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
